// File: rtl/tracker_pkg.sv
// tracker_pkg: shared pixel type, frame geometry defaults and sampler FSM states
package tracker_pkg;
  localparam int GRID = 16;
  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 600;
  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } pixel_t;
  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE} state_t;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: x/y position of the current pixel in a raster stream, cleared by start-of-frame
module raster_counter #(
  parameter int H_ACTIVE = 800,
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid,
  input  logic          sof,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y
);
  logic [CW-1:0] xr, yr;
  assign x = sof ? '0 : xr;
  assign y = sof ? '0 : yr;
  // step to the next position on each valid pixel, wrapping at end of line
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      xr <= '0;
      yr <= '0;
    end else if (valid) begin
      xr <= x == CW'(H_ACTIVE - 1) ? '0 : x + 1'b1;
      yr <= x == CW'(H_ACTIVE - 1) ? y + 1'b1 : y;
    end
endmodule

// File: rtl/roi_sampler.sv
// roi_sampler: picks a 16x16 strided grid of pixels from a region of interest in one frame
module roi_sampler
  import tracker_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int CW = 12
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [9:0]    i_R,
  input  logic [9:0]    i_G,
  input  logic [9:0]    i_B,
  input  logic          i_valid,
  input  logic          i_sof,
  input  logic [CW-1:0] i_roi_x,
  input  logic [CW-1:0] i_roi_y,
  input  logic [1:0]    i_stride_log2,
  input  logic          i_arm,
  output logic [9:0]    o_R,
  output logic [9:0]    o_G,
  output logic [9:0]    o_B,
  output logic          o_take,
  output logic [7:0]    o_idx,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);
  state_t state, state_d;
  pixel_t px;
  logic [CW-1:0] x, y, rx, ry, dx, dy, qx, qy, m;
  logic [CW:0] ex, ey;
  logic [1:0] s;
  logic [7:0] cnt;
  logic sof_px, arm_ok, hit, cap, take, done, abort, err;
  assign {o_R, o_G, o_B} = {px.r, px.g, px.b};
  raster_counter #(.H_ACTIVE(H_ACTIVE), .CW(CW)) u_rc (
    .clk(i_clk), .rst_n(i_rst_n), .valid(i_valid), .sof(i_sof), .x(x), .y(y)
  );
  // range check, sample decode and next-state selection
  always_comb begin
    ex = {1'b0, i_roi_x} + ((CW+1)'(GRID - 1) << i_stride_log2);
    ey = {1'b0, i_roi_y} + ((CW+1)'(GRID - 1) << i_stride_log2);
    arm_ok = ex <= (CW+1)'(H_ACTIVE - 1) && ey <= (CW+1)'(V_ACTIVE - 1);
    dx = x - rx;
    dy = y - ry;
    qx = dx >> s;
    qy = dy >> s;
    m = ~({CW{1'b1}} << s);
    hit = x >= rx && y >= ry && (dx & m) == '0 && (dy & m) == '0 && qx < CW'(GRID) && qy < CW'(GRID);
    sof_px = i_valid && i_sof;
    cap = i_valid && ((state == CAPTURE && !i_sof) || (state == WAIT_SOF && i_sof));
    take = cap && hit;
    done = take && cnt == 8'd255;
    abort = state == CAPTURE && sof_px;
    err = (state == IDLE && i_arm && !arm_ok) || abort;
    state_d = state == IDLE ? (i_arm && arm_ok ? WAIT_SOF : IDLE) :
              state == WAIT_SOF ? (sof_px ? CAPTURE : WAIT_SOF) :
              (abort || done ? IDLE : CAPTURE);
  end
  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_d;
  // latch ROI on any arm seen in IDLE; the sample count restarts while idle
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      rx <= '0;
      ry <= '0;
      s <= '0;
      cnt <= '0;
    end else begin
      if (state == IDLE && i_arm) begin
        rx <= i_roi_x;
        ry <= i_roi_y;
        s <= i_stride_log2;
      end
      cnt <= state == IDLE ? '0 : cnt + {7'd0, take};
    end
  // registered sample and status outputs; busy lags state so it stays high with done
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      px <= '0;
      o_idx <= '0;
      o_take <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_err <= 1'b0;
    end else begin
      o_take <= take;
      o_done <= done;
      o_err <= err;
      o_busy <= state != IDLE;
      if (take) begin
        px <= {i_R, i_G, i_B};
        o_idx <= {qy[3:0], qx[3:0]};
      end
    end
endmodule

// File: doc/roi_sampler.md
# roi_sampler

Capture-front-end for the object tracker. Sits directly upstream of the 16x16 picture buffer. Watches the raster-ordered camera pixel stream and picks a 16x16 grid of samples from a programmable region of interest (ROI), with a power-of-two stride. It forwards each selected pixel with a one-cycle take strobe, so the buffer fills in row-major order. Once armed, it captures one frame's ROI and then reports done.

## Interface
- H_ACTIVE, 800: active pixels per line
- V_ACTIVE, 600: active lines per frame
- GRID, 16: samples per ROI side (fixed to match the picture buffer)
- CW, 12: coordinate counter width
- i_clk  in  1  system clock, all logic on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_R, i_G, i_B  in  10 each  pixel colour, qualified by i_valid
- i_valid  in  1  pixel present this cycle
- i_sof  in  1  first pixel of frame; only meaningful with i_valid=1
- i_roi_x, i_roi_y  in  CW each  ROI top-left pixel coordinate
- i_stride_log2  in  2  sample spacing = 1<<i_stride_log2 (1, 2, 4, 8)
- i_arm  in  1  request one capture; level sampled each cycle
- o_R, o_G, o_B  out  10 each  sampled pixel, valid when o_take=1
- o_take  out  1  one-cycle strobe per sample (drives picture buffer take)
- o_idx  out  8  sample index row*16+col, valid with o_take
- o_busy  out  1  high in WAIT_SOF and CAPTURE
- o_done  out  1  one-cycle pulse after the 256th sample
- o_err  out  1  one-cycle pulse on rejected arm or aborted capture

## Operation
- FSM states:
  - IDLE: waiting for an arm request.
  - WAIT_SOF: armed, waiting for the next frame start.
  - CAPTURE: counting pixels and emitting samples.
- IDLE with i_arm=1:
  - Latch roi_x, roi_y and stride into internal registers. Later changes to the inputs are ignored until the next arm.
  - Range check: roi_x + 15*stride <= H_ACTIVE-1 and roi_y + 15*stride <= V_ACTIVE-1.
  - Check fails: pulse o_err and stay in IDLE.
  - Check passes: go to WAIT_SOF.
- i_arm is ignored outside IDLE.
- WAIT_SOF: when i_valid=1 and i_sof=1, go to CAPTURE. This same pixel is coordinate (0,0) and is evaluated for sampling.
- Pixel counters x and y (CW bits) advance only on i_valid.
  - x wraps from H_ACTIVE-1 to 0 and then y increments.
  - i_sof forces both counters to 0 for the current pixel.
- Sample condition for pixel (x,y), with dx=x-roi_x, dy=y-roi_y, s=stride_log2:
  - x >= roi_x and y >= roi_y;
  - dx[s-1:0]==0 and dy[s-1:0]==0;
  - dx>>s < 16 and dy>>s < 16.
- On a sample:
  - Emit the pixel, then increment the sample counter.
  - o_idx = (dy>>s)*16 + (dx>>s). This always equals the sample counter, because the stream is raster-ordered.
- After sample 255: pulse o_done, return to IDLE.
- i_sof during CAPTURE before 256 samples (dropped pixels upstream): pulse o_err, return to IDLE, emit nothing for that pixel.
- i_valid=0 cycles: no counter change and no take.

## Timing
- Outputs are registered. Latency is 1 cycle from input pixel to o_take and o_R/G/B.
- o_done is asserted in the same cycle as the final o_take (idx 255). o_busy drops in the next cycle.
- Rejected-arm o_err appears 1 cycle after i_arm.
- Abort o_err appears 1 cycle after the offending i_sof.
- Minimum re-arm: i_arm in the cycle after o_done is accepted.
- Back-to-back valid pixels are supported with no bubbles.
- Reset (asynchronous, any state):
  - State goes to IDLE; all counters and latched ROI registers go to 0.
  - o_R/G/B = 0, o_take = 0, o_idx = 0, o_busy = 0, o_done = 0, o_err = 0.
  - A capture in progress is discarded silently (no o_err).

## Structure
- Shared package `tracker_pkg`:
  - pixel typedef (three 10-bit channels);
  - GRID and the H_ACTIVE/V_ACTIVE defaults;
  - FSM state enum.
- One natural sub-module: `raster_counter`, which holds the x/y counters with wrap and sof clear. It is reusable by other stream stages.
- Everything else (FSM, range check, sample decode, output registers) lives in roi_sampler.

## Test plan
- Reset mid-capture:
  - Stimulus: arm with roi (100,50), stride 1; stream a frame; pull i_rst_n low after 40 takes.
  - Required: all outputs 0 immediately, no o_err, state IDLE.
  - After a new arm, capture restarts at idx 0.
- Basic capture:
  - Stimulus: roi (100,50), stride 1, pixel value R=x, G=y, B=x^y.
  - Required: exactly 256 o_take pulses, the first carrying (R=100, G=50) at idx 0 and the last carrying (115,65) at idx 255.
  - o_done coincides with the last take.
- Stride:
  - Stimulus: roi (0,0), stride_log2=3.
  - Required: samples at x,y in {0,8,...,120}; idx 17 carries pixel (8,8); 256 takes total.
- Range reject:
  - Stimulus: roi_x=790, stride 1 (790+15 > 799).
  - Required: o_err pulse 1 cycle after arm, no o_busy, no takes.
- Gapped stream and abort:
  - Stimulus: random i_valid=0 gaps.
  - Required: identical sample values and idx sequence to the gap-free run.
  - Stimulus: i_sof injected after 100 takes.
  - Required: o_err pulse, return to IDLE, no further takes.
- Ignored arm:
  - Stimulus: i_arm held high through CAPTURE with changing i_roi_x.
  - Required: capture uses the originally latched ROI.
  - Stimulus: i_arm still high after o_done.
  - Required: a new capture begins on the next frame.
